// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: two-client round-robin APB master in front of one APB slave.
// Each client request becomes a SETUP/ACCESS sequence. The granted client gets
// back a one-cycle done pulse with its read data.
// Optional watchdog: define APB_ARB_TIMEOUT_EN to abort ACCESS phases that last
// TIMEOUT cycles without PREADY. An aborted access reports err=1, and a read
// that was aborted returns rdata=0.
module apb_ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;          // client owning the current access
  logic                last_grant_q, last_grant_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;          // doubles as the latched request
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                pick;                      // winner if a grant happens now
  logic                timeout_hit;               // ACCESS limit reached with no PREADY

  // Round-robin pick: a lone request wins; under contention the port not served last wins.
  assign pick = req1_valid && (!req0_valid || !last_grant_q);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count ACCESS cycles; the count is zero on the first ACCESS cycle.
  always_comb cnt_d = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;

  // Watchdog counter register.
  always_ff @(posedge PCLK) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The TIMEOUT-th ACCESS cycle without PREADY ends the access. PREADY in that same cycle still wins.
  assign timeout_hit = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output logic for the APB sequence.
  always_comb begin
    // NOTE: every _d is given a default before the case, so no path can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d  = pick;
          pwrite_d = pick ? req1_write : req0_write;
          paddr_d  = pick ? req1_addr  : req0_addr;
          pwdata_d = pick ? req1_wdata : req0_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (PREADY || timeout_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
          if (grant_q) begin
            done1_d = 1'b1;
            err1_d  = timeout_hit;
            if (!pwrite_q) rdata1_d = timeout_hit ? '0 : PRDATA;
          end else begin
            done0_d = 1'b1;
            err0_d  = timeout_hit;
            if (!pwrite_q) rdata0_d = timeout_hit ? '0 : PRDATA;
          end
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset discards any access in flight.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (PRESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule
